// File: rtl/counter_pkg.sv
// Shared constants for the datapath counters: direction and terminal-mode
// encodings plus the default datapath width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/add.sv
// Plain WIDTH-bit adder shared by the datapath; the carry out is discarded,
// so all arithmetic is modulo 2^WIDTH.
module add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mod_counter_next.sv
// Combinational step function of the modulo counter: terminal detection and
// the candidate next count for an enabled cycle.
module mod_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] next_count,
  output logic             tc,
  output logic             term_event
);

  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] stepped;

  // A zero limit selects the full 2^WIDTH range.
  assign top = (limit == '0) ? '1 : limit - WIDTH'(1);

  // Adding all-ones is a decrement in modulo arithmetic.
  assign step_val = (dir == DIR_UP) ? WIDTH'(1) : '1;

  add #(.WIDTH(WIDTH)) u_add (
    .a   (count),
    .b   (step_val),
    .sum (stepped)
  );

  always_comb begin
    tc = 1'b0;
    if (dir == DIR_UP) begin
      tc = (count >= top);
    end else begin
      tc = (count == '0);
    end
  end

  assign term_event = tc;

  always_comb begin
    next_count = stepped;
    if (tc) begin
      case ({dir, sat})
        {DIR_UP,   MODE_WRAP}: next_count = '0;
        {DIR_UP,   MODE_SAT }: next_count = top;
        {DIR_DOWN, MODE_WRAP}: next_count = top;
        {DIR_DOWN, MODE_SAT }: next_count = '0;
        default:               next_count = stepped;
      endcase
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Runtime-modulus up/down counter with load, clear, wrap/saturate selection,
// terminal-count flag, one-cycle wrap pulse and sticky overflow.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] next_count;
  logic             term_event;

  mod_counter_next #(.WIDTH(WIDTH)) u_next (
    .count      (count),
    .dir        (dir),
    .sat        (sat),
    .limit      (limit),
    .next_count (next_count),
    .tc         (tc),
    .term_event (term_event)
  );

  // Priority is clr > load > en > hold; wrap is cleared on every non-terminal edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (en) begin
      count <= next_count;
      wrap  <= term_event;
      if (term_event) begin
        ovf <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed scenarios followed by random
// traffic, all compared against an integer reference model.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr, load, en, dir, sat;
  logic [7:0] load_val, limit;
  logic [7:0] count;
  logic       tc, wrap, ovf;

  int checks = 0;
  int errors = 0;

  int m_count = 0;
  int m_wrap  = 0;
  int m_ovf   = 0;

  mod_counter #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .dir      (dir),
    .sat      (sat),
    .limit    (limit),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int top_of(input int lim);
    return (lim == 0) ? 255 : lim - 1;
  endfunction

  // Drive one cycle's inputs, check tc before the edge, then check registers after it.
  task automatic do_cycle(input logic c, input logic l, input logic [7:0] lv,
                          input logic e, input logic d, input logic s,
                          input logic [7:0] lim);
    int top;
    int at_term;
    clr = c; load = l; load_val = lv; en = e; dir = d; sat = s; limit = lim;
    #1;
    top = top_of(int'(lim));
    at_term = d ? (m_count >= top) : (m_count == 0);
    check("tc", 32'(tc), 32'(at_term));
    if (c) begin
      m_count = 0; m_wrap = 0; m_ovf = 0;
    end else if (l) begin
      m_count = int'(lv); m_wrap = 0;
    end else if (e) begin
      if (at_term != 0) begin
        if (d) m_count = s ? top : 0;
        else   m_count = s ? 0 : top;
        m_wrap = 1; m_ovf = 1;
      end else begin
        m_count = d ? (m_count + 1) % 256 : (m_count + 255) % 256;
        m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(m_count));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  initial begin
    reset = 1'b0;
    clr = 0; load = 0; load_val = 0; en = 0; dir = 1; sat = 0; limit = 0;
    #3;
    check("rst_count", 32'(count), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Async reset between edges while holding 0x37.
    do_cycle(0, 1, 8'h37, 0, 1, 0, 8'd0);
    check("load_37", 32'(count), 32'h37);
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 32'(count), 32'h0);
    check("async_wrap", 32'(wrap), 32'h0);
    check("async_ovf", 32'(ovf), 32'h0);
    m_count = 0; m_wrap = 0; m_ovf = 0;
    @(negedge clk);
    reset = 1'b1;
    do_cycle(0, 0, 8'h00, 1, 1, 0, 8'd0);
    check("resume_1", 32'(count), 32'h1);

    // Up wrap at limit 10.
    do_cycle(1, 0, 8'h00, 0, 1, 0, 8'd10);
    for (int i = 0; i < 10; i++) do_cycle(0, 0, 8'h00, 1, 1, 0, 8'd10);
    check("upwrap_count", 32'(count), 32'h0);
    check("upwrap_wrap", 32'(wrap), 32'h1);
    do_cycle(0, 0, 8'h00, 1, 1, 0, 8'd10);
    check("upwrap_ovf_sticky", 32'(ovf), 32'h1);

    // Down wrap from 2, then saturate at 0.
    do_cycle(0, 1, 8'd2, 0, 0, 0, 8'd10);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 8'h00, 1, 0, 0, 8'd10);
    check("down_wrap_9", 32'(count), 32'd9);
    do_cycle(0, 1, 8'd0, 0, 0, 1, 8'd10);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 8'h00, 1, 0, 1, 8'd10);
    check("down_sat_0", 32'(count), 32'd0);

    // Full range with limit 0, wrap then saturate.
    do_cycle(0, 1, 8'hFE, 0, 1, 0, 8'd0);
    for (int i = 0; i < 2; i++) do_cycle(0, 0, 8'h00, 1, 1, 0, 8'd0);
    check("full_wrap", 32'(count), 32'h00);
    do_cycle(0, 1, 8'hFE, 0, 1, 1, 8'd0);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 8'h00, 1, 1, 1, 8'd0);
    check("full_sat", 32'(count), 32'hFF);

    // clr beats load and en; then out-of-range load.
    do_cycle(1, 1, 8'h55, 1, 1, 0, 8'd10);
    check("prio_ovf", 32'(ovf), 32'h0);
    do_cycle(0, 1, 8'd200, 0, 1, 0, 8'd10);
    do_cycle(0, 0, 8'h00, 1, 1, 0, 8'd10);
    check("oor_wrap", 32'(count), 32'd0);
    do_cycle(0, 1, 8'd200, 0, 1, 1, 8'd10);
    do_cycle(0, 0, 8'h00, 1, 1, 1, 8'd10);
    check("oor_sat", 32'(count), 32'd9);
    for (int i = 0; i < 2; i++) do_cycle(0, 0, 8'h00, 0, 1, 1, 8'd10);
    check("hold_wrap", 32'(wrap), 32'h0);

    // limit 1: every enabled cycle is terminal.
    do_cycle(1, 0, 8'h00, 0, 1, 0, 8'd1);
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 8'h00, 1, i[0], i[1], 8'd1);
    check("lim1_wrap", 32'(wrap), 32'h1);

    // Random traffic, biased toward small limits to hit terminals often.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] lim;
      case ($urandom_range(0, 4))
        0: lim = 8'd0;
        1: lim = 8'd1;
        2: lim = 8'($urandom_range(2, 6));
        3: lim = 8'd10;
        default: lim = 8'($urandom);
      endcase
      do_cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
               8'($urandom), ($urandom_range(0, 3) != 0),
               1'($urandom), 1'($urandom), lim);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
